// File: rtl/speed_pong_pkg.sv
// Shared types and default timing for the speed-pong input path.
// Lane numbering matches the board buttons so paddle logic can index by name.
package speed_pong_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btnState_t;

    typedef enum logic {
        PH_DELAY,
        PH_PERIOD
    } repeatPhase_t;

    localparam int DB_CYCLES_DEF     = 500000;
    localparam int REPEAT_DELAY_DEF  = 25000000;
    localparam int REPEAT_PERIOD_DEF = 5000000;

    localparam int BTN_P1UP   = 0;
    localparam int BTN_P1DOWN = 1;
    localparam int BTN_P2UP   = 2;
    localparam int BTN_P2DOWN = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_lane.sv
// One pushbutton: two-flop synchroniser, debounce FSM and auto-repeat timer.
// All outputs are registered; pulses last exactly one clock.
module button_debounce_lane
    import speed_pong_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic sysResetN,
    input  logic btnN,
    output logic level,
    output logic pressPulse,
    output logic releasePulse,
    output logic repeatPulse
);

    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int TMR_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES);
    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    logic              sync1_reg;
    logic              sync2_reg;
    btnState_t         state_reg;
    repeatPhase_t      phase_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    logic [TMR_W-1:0]  tmr_reg;
    logic              level_reg;
    logic              press_reg;
    logic              release_reg;
    logic              repeat_reg;

    logic pressed;
    logic repeat_due;

    assign pressed    = ~sync2_reg;
    assign repeat_due = (phase_reg == PH_DELAY) ? (tmr_reg == DELAY_LAST)
                                                : (tmr_reg == PERIOD_LAST);

    always_ff @(posedge clk or negedge sysResetN) begin
        if (!sysResetN) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            state_reg   <= IDLE;
            phase_reg   <= PH_DELAY;
            db_cnt_reg  <= '0;
            tmr_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            sync1_reg   <= btnN;
            sync2_reg   <= sync1_reg;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (pressed) begin
                        state_reg  <= PRESS_WAIT;
                        db_cnt_reg <= DB_ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (!pressed) begin
                        state_reg  <= IDLE;
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg <= HELD;
                        level_reg <= 1'b1;
                        press_reg <= 1'b1;
                        tmr_reg   <= '0;
                        phase_reg <= PH_DELAY;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_ONE;
                    end
                end

                HELD: begin
                    if (!pressed) begin
                        state_reg  <= RELEASE_WAIT;
                        db_cnt_reg <= DB_ONE;
                    end else if (REPEAT_EN != 0) begin
                        if (repeat_due) begin
                            repeat_reg <= 1'b1;
                            tmr_reg    <= '0;
                            phase_reg  <= PH_PERIOD;
                        end else begin
                            tmr_reg <= tmr_reg + TMR_ONE;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    // Timer stays frozen here so a bounce does not reset the repeat cadence.
                    if (pressed) begin
                        state_reg <= HELD;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg   <= IDLE;
                        level_reg   <= 1'b0;
                        release_reg <= 1'b1;
                        db_cnt_reg  <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_ONE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign level        = level_reg;
    assign pressPulse   = press_reg;
    assign releasePulse = release_reg;
    assign repeatPulse  = repeat_reg;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low board buttons into clean active-high level and pulse signals.
// Wiring only: one independent debounce lane per button.
module button_conditioner
    import speed_pong_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic               clk,
    input  logic               sysResetN,
    input  logic [NUM_BTN-1:0] btnN,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] pressPulse,
    output logic [NUM_BTN-1:0] releasePulse,
    output logic [NUM_BTN-1:0] repeatPulse
);

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_lane
        button_debounce_lane #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_lane (
            .clk          (clk),
            .sysResetN    (sysResetN),
            .btnN         (btnN[gi]),
            .level        (level[gi]),
            .pressPulse   (pressPulse[gi]),
            .releasePulse (releasePulse[gi]),
            .repeatPulse  (repeatPulse[gi])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts every
// cycle's outputs, and directed scenarios pin the documented edge numbers.
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk;
    logic          sysResetN;
    logic [NB-1:0] btnN;
    logic [NB-1:0] level;
    logic [NB-1:0] pressPulse;
    logic [NB-1:0] releasePulse;
    logic [NB-1:0] repeatPulse;

    button_conditioner #(
        .NUM_BTN       (NB),
        .DB_CYCLES     (DB),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk          (clk),
        .sysResetN    (sysResetN),
        .btnN         (btnN),
        .level        (level),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .repeatPulse  (repeatPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4*NB-1:0] exp_q[$];

    // Reference model state: level, length of the current run of samples that
    // disagree with level, held-cycle count and the two-deep raw sample history.
    logic m_level[NB];
    int   m_run[NB];
    int   m_ticks[NB];
    logic m_h1[NB];
    logic m_h2[NB];

    initial begin : model
        logic [NB-1:0] lv, pr, rl, rp;
        logic pressed;
        forever begin
            @(posedge clk);
            pr = '0;
            rl = '0;
            rp = '0;
            for (int i = 0; i < NB; i++) begin
                if (!sysResetN) begin
                    m_level[i] = 1'b0;
                    m_run[i]   = 0;
                    m_ticks[i] = 0;
                    m_h1[i]    = 1'b1;
                    m_h2[i]    = 1'b1;
                end else begin
                    pressed = !m_h2[i];
                    m_h2[i] = m_h1[i];
                    m_h1[i] = btnN[i];
                    if (!m_level[i]) begin
                        if (pressed) begin
                            m_run[i]++;
                            if (m_run[i] == DB + 1) begin
                                m_level[i] = 1'b1;
                                pr[i]      = 1'b1;
                                m_run[i]   = 0;
                                m_ticks[i] = 0;
                            end
                        end else begin
                            m_run[i] = 0;
                        end
                    end else begin
                        if (!pressed) begin
                            m_run[i]++;
                            if (m_run[i] == DB + 1) begin
                                m_level[i] = 1'b0;
                                rl[i]      = 1'b1;
                                m_run[i]   = 0;
                            end
                        end else begin
                            // Only a cleanly held cycle (no pending release run) advances repeat time.
                            if (m_run[i] == 0) begin
                                m_ticks[i]++;
                                if (m_ticks[i] >= RD && ((m_ticks[i] - RD) % RP) == 0)
                                    rp[i] = 1'b1;
                            end
                            m_run[i] = 0;
                        end
                    end
                end
                lv[i] = m_level[i];
            end
            exp_q.push_back({lv, pr, rl, rp});
        end
    end

    initial begin : monitor
        logic [4*NB-1:0] e;
        logic [4*NB-1:0] a;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {level, pressPulse, releasePulse, repeatPulse};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard cycle %0d: got lvl=%b prs=%b rel=%b rep=%b, expected lvl=%b prs=%b rel=%b rep=%b",
                             cyc, a[15:12], a[11:8], a[7:4], a[3:0], e[15:12], e[11:8], e[7:4], e[3:0]);
                end else if (|a[11:0]) begin
                    $display("cycle %0d: lvl=%b prs=%b rel=%b rep=%b", cyc, a[15:12], a[11:8], a[7:4], a[3:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NB-1:0] v);
        @(negedge clk);
        #1;
        btnN = v;
    endtask

    initial begin : stimulus
        sysResetN = 1'b0;
        btnN      = '1;
        tick(3);
        check("reset_level", level, 4'b0000);
        check("reset_press", pressPulse, 4'b0000);
        check("reset_release", releasePulse, 4'b0000);
        check("reset_repeat", repeatPulse, 4'b0000);
        @(negedge clk);
        #1;
        sysResetN = 1'b1;
        tick(3);

        // Clean press on lane 0
        drive(4'b1110);
        tick(7);
        check("s1_level_edge7", level, 4'b0001);
        check("s1_press_edge7", pressPulse, 4'b0001);
        tick(1);
        check("s1_press_one_cycle", pressPulse, 4'b0000);
        check("s1_level_held", level, 4'b0001);
        drive(4'b1111);
        tick(12);
        check("s1_released", level, 4'b0000);

        // Glitch on lane 1: three low samples are rejected
        drive(4'b1101);
        tick(3);
        drive(4'b1111);
        tick(10);
        check("s2_glitch_level", level, 4'b0000);

        // Hold lane 2 with repeats, then a short bounce, then release
        drive(4'b1011);
        tick(7);
        check("s3_press_edge7", pressPulse, 4'b0100);
        tick(10);
        check("s3_repeat_edge17", repeatPulse, 4'b0100);
        check("s3_no_press_edge17", pressPulse, 4'b0000);
        tick(3);
        check("s3_repeat_edge20", repeatPulse, 4'b0100);
        tick(3);
        check("s3_repeat_edge23", repeatPulse, 4'b0100);
        tick(3);
        check("s3_repeat_edge26", repeatPulse, 4'b0100);
        drive(4'b1111);
        tick(2);
        drive(4'b1011);
        tick(1);
        check("s4_bounce_no_repeat_edge29", repeatPulse, 4'b0000);
        check("s4_bounce_level", level, 4'b0100);
        tick(3);
        check("s4_repeat_resumes_edge32", repeatPulse, 4'b0100);
        tick(7);
        drive(4'b1111);
        tick(6);
        check("s4_level_edge45", level, 4'b0100);
        check("s4_no_release_edge45", releasePulse, 4'b0000);
        tick(1);
        check("s4_release_edge46", releasePulse, 4'b0100);
        check("s4_level_low_edge46", level, 4'b0000);
        tick(5);

        // Reset while lane 0 is held
        drive(4'b1110);
        tick(10);
        check("s5_held_before_reset", level, 4'b0001);
        @(negedge clk);
        #1;
        sysResetN = 1'b0;
        #1;
        check("s5_reset_level", level, 4'b0000);
        check("s5_reset_press", pressPulse, 4'b0000);
        check("s5_reset_release", releasePulse, 4'b0000);
        check("s5_reset_repeat", repeatPulse, 4'b0000);
        tick(2);
        @(negedge clk);
        #1;
        sysResetN = 1'b1;
        tick(6);
        check("s5_no_early_press", pressPulse, 4'b0000);
        tick(1);
        check("s5_press_after_reset", pressPulse, 4'b0001);
        drive(4'b1111);
        tick(12);

        // All four lanes pressed together
        drive(4'b0000);
        tick(7);
        check("s6_press_all", pressPulse, 4'b1111);
        check("s6_level_all", level, 4'b1111);
        drive(4'b1111);
        tick(10);
        check("s6_released_all", level, 4'b0000);

        // Randomised bouncing with occasional resets
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 99) < 6)
                    btnN[i] = ~btnN[i];
            sysResetN = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        #1;
        sysResetN = 1'b1;
        btnN      = '1;
        tick(20);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
